id_ex_stage: RTL and testbench

Decode/operand-fetch stage of the pipelined CPU, sitting directly upstream of the 32-entry register file. It decodes the instruction handed over by fetch, drives the register file's two read addresses, and bypasses the same-cycle writeback value. It detects load-use hazards and latches operands, immediate and control into the ID/EX pipeline register under a valid/ready handshake with flush.

---
 rtl/id_ex_stage_if.sv | 51 +++++
 rtl/id_ex_stage.sv | 180 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if : fetch / regfile / writeback / EX signals around the ID stage
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface id_ex_stage_if #(
  parameter int WIDTH = 32
);
  logic              if_valid;
  logic [31:0]       if_instr;
  logic [WIDTH-1:0]  if_pc;
  logic              id_ready;
  logic [4:0]        rf_ra0;
  logic [4:0]        rf_ra1;
  logic [WIDTH-1:0]  rf_rd0;
  logic [WIDTH-1:0]  rf_rd1;
  logic              wb_we;
  logic [4:0]        wb_wa;
  logic [WIDTH-1:0]  wb_wd;
  logic              flush;
  logic              ex_ready;
  logic              ex_valid;
  logic [WIDTH-1:0]  ex_pc;
  logic [WIDTH-1:0]  ex_a;
  logic [WIDTH-1:0]  ex_b;
  logic [WIDTH-1:0]  ex_imm;
  logic [5:0]        ex_op;
  logic [5:0]        ex_funct;
  logic [4:0]        ex_wa;
  logic              ex_reg_we;
  logic              ex_is_load;

  // slave: the ID stage itself
  modport slave (
    input  if_valid, if_instr, if_pc, rf_rd0, rf_rd1, wb_we, wb_wa, wb_wd,
           flush, ex_ready,
    output id_ready, rf_ra0, rf_ra1, ex_valid, ex_pc, ex_a, ex_b, ex_imm,
           ex_op, ex_funct, ex_wa, ex_reg_we, ex_is_load
  );

  // master: the surrounding pipeline (fetch, regfile, writeback, EX)
  modport master (
    output if_valid, if_instr, if_pc, rf_rd0, rf_rd1, wb_we, wb_wa, wb_wd,
           flush, ex_ready,
    input  id_ready, rf_ra0, rf_ra1, ex_valid, ex_pc, ex_a, ex_b, ex_imm,
           ex_op, ex_funct, ex_wa, ex_reg_we, ex_is_load
  );
endinterface

`default_nettype wire

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage : MIPS decode/operand fetch with WB bypass, load-use stall, ID/EX reg
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module id_ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [5:0]       op;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [WIDTH-1:0] imm_sx;
  logic [WIDTH-1:0] imm_zx;
  logic [WIDTH-1:0] imm_j;

  assign op     = bus.if_instr[31:26];
  assign rs     = bus.if_instr[25:21];
  assign rt     = bus.if_instr[20:16];
  assign rd     = bus.if_instr[15:11];
  assign imm_sx = {{(WIDTH-16){bus.if_instr[15]}}, bus.if_instr[15:0]};
  assign imm_zx = {{(WIDTH-16){1'b0}}, bus.if_instr[15:0]};
  assign imm_j  = {{(WIDTH-26){1'b0}}, bus.if_instr[25:0]};

  assign bus.rf_ra0 = rs;
  assign bus.rf_ra1 = rt;

  logic [4:0]       dec_dest;
  logic             dec_we;
  logic             uses_rs;
  logic             uses_rt;
  logic             dec_load;
  logic [WIDTH-1:0] dec_imm;

  always_comb begin
    dec_dest = 5'd0;
    dec_we   = 1'b0;
    uses_rs  = 1'b0;
    uses_rt  = 1'b0;
    dec_load = 1'b0;
    dec_imm  = '0;
    unique case (op)
      OP_RTYPE: begin
        dec_dest = rd;
        dec_we   = 1'b1;
        uses_rs  = 1'b1;
        uses_rt  = 1'b1;
        dec_imm  = imm_sx;
      end
      OP_ADDI, OP_LW: begin
        dec_dest = rt;
        dec_we   = 1'b1;
        uses_rs  = 1'b1;
        dec_load = (op == OP_LW);
        dec_imm  = imm_sx;
      end
      OP_ORI: begin
        dec_dest = rt;
        dec_we   = 1'b1;
        uses_rs  = 1'b1;
        dec_imm  = imm_zx;
      end
      OP_SW, OP_BEQ: begin
        uses_rs  = 1'b1;
        uses_rt  = 1'b1;
        dec_imm  = imm_sx;
      end
      OP_J:    dec_imm = imm_j;
      default: dec_imm = '0;
    endcase
  end

  // A write to $0 never produces a destination, so reg_we is derived from wa.
  logic [4:0]       dec_wa;
  assign dec_wa = (dec_we && dec_dest != 5'd0) ? dec_dest : 5'd0;

  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] opnd_b;
  assign opnd_a = (bus.wb_we && bus.wb_wa != 5'd0 && bus.wb_wa == rs) ? bus.wb_wd : bus.rf_rd0;
  assign opnd_b = (bus.wb_we && bus.wb_wa != 5'd0 && bus.wb_wa == rt) ? bus.wb_wd : bus.rf_rd1;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       funct_q, funct_d;
  logic [4:0]       wa_q, wa_d;
  logic             load_q, load_d;

  logic hazard;
  assign hazard = bus.if_valid && valid_q && load_q && (wa_q != 5'd0) &&
                  ((uses_rs && wa_q == rs) || (uses_rt && wa_q == rt));

  assign bus.id_ready = bus.ex_ready && !hazard;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    op_d    = op_q;
    funct_d = funct_q;
    wa_d    = wa_q;
    load_d  = load_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (!bus.ex_ready) begin
      valid_d = valid_q;
    end else if (hazard) begin
      valid_d = 1'b0;
    end else if (bus.if_valid) begin
      valid_d = 1'b1;
      pc_d    = bus.if_pc;
      a_d     = opnd_a;
      b_d     = opnd_b;
      imm_d   = dec_imm;
      op_d    = op;
      funct_d = bus.if_instr[5:0];
      wa_d    = dec_wa;
      load_d  = dec_load;
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      op_q    <= 6'd0;
      funct_q <= 6'd0;
      wa_q    <= 5'd0;
      load_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      op_q    <= op_d;
      funct_q <= funct_d;
      wa_q    <= wa_d;
      load_q  <= load_d;
    end
  end

  assign bus.ex_valid   = valid_q;
  assign bus.ex_pc      = pc_q;
  assign bus.ex_a       = a_q;
  assign bus.ex_b       = b_q;
  assign bus.ex_imm     = imm_q;
  assign bus.ex_op      = op_q;
  assign bus.ex_funct   = funct_q;
  assign bus.ex_wa      = wa_q;
  assign bus.ex_reg_we  = (wa_q != 5'd0);
  assign bus.ex_is_load = load_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage : directed + random checks of id_ex_stage against a reference model
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_stage;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  id_ex_stage_if #(.WIDTH(WIDTH)) bus ();

  id_ex_stage #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference ID/EX contents
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = '0, m_a = '0, m_b = '0, m_imm = '0;
  logic [5:0]  m_op = '0, m_funct = '0;
  logic [4:0]  m_wa = '0;
  logic        m_load = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void ref_decode(input logic [31:0] ins, output logic [31:0] imm,
                                     output logic [4:0] dst, output logic urs,
                                     output logic urt, output logic ld);
    logic [31:0] sx;
    logic [31:0] zx;
    sx  = {{16{ins[15]}}, ins[15:0]};
    zx  = {16'h0000, ins[15:0]};
    dst = 5'd0; imm = 32'd0; urs = 1'b0; urt = 1'b0; ld = 1'b0;
    case (ins[31:26])
      6'h00:        begin dst = ins[15:11]; urs = 1'b1; urt = 1'b1; imm = sx; end
      6'h08:        begin dst = ins[20:16]; urs = 1'b1; imm = sx; end
      6'h23:        begin dst = ins[20:16]; urs = 1'b1; imm = sx; ld = 1'b1; end
      6'h0D:        begin dst = ins[20:16]; urs = 1'b1; imm = zx; end
      6'h2B, 6'h04: begin urs = 1'b1; urt = 1'b1; imm = sx; end
      6'h02:        imm = {6'b0, ins[25:0]};
      default:      imm = 32'd0;
    endcase
  endfunction

  // One clock: check combinational outputs, advance the model, check ID/EX.
  task automatic cycle();
    logic [4:0]  rs, rt, dst;
    logic [31:0] imm, a, b;
    logic        urs, urt, ld, haz, was_reset;
    #1;
    rs = bus.if_instr[25:21];
    rt = bus.if_instr[20:16];
    ref_decode(bus.if_instr, imm, dst, urs, urt, ld);
    haz = bus.if_valid && m_valid && m_load && (m_wa != 0) &&
          ((urs && m_wa == rs) || (urt && m_wa == rt));
    check("rf_ra0", {27'b0, bus.rf_ra0}, {27'b0, rs});
    check("rf_ra1", {27'b0, bus.rf_ra1}, {27'b0, rt});
    check("id_ready", {31'b0, bus.id_ready}, {31'b0, bus.ex_ready && !haz});
    a = (bus.wb_we && bus.wb_wa != 0 && bus.wb_wa == rs) ? bus.wb_wd : bus.rf_rd0;
    b = (bus.wb_we && bus.wb_wa != 0 && bus.wb_wa == rt) ? bus.wb_wd : bus.rf_rd1;
    was_reset = !rst_n;
    if (!rst_n) begin
      m_valid = 0; m_pc = 0; m_a = 0; m_b = 0; m_imm = 0;
      m_op = 0; m_funct = 0; m_wa = 0; m_load = 0;
    end else if (bus.flush) m_valid = 0;
    else if (!bus.ex_ready) m_valid = m_valid;
    else if (haz) m_valid = 0;
    else if (bus.if_valid) begin
      m_valid = 1; m_pc = bus.if_pc; m_a = a; m_b = b; m_imm = imm;
      m_op = bus.if_instr[31:26]; m_funct = bus.if_instr[5:0];
      m_wa = dst; m_load = ld;
    end else m_valid = 0;
    @(posedge clk);
    #1;
    check("ex_valid", {31'b0, bus.ex_valid}, {31'b0, m_valid});
    if (m_valid || was_reset) begin
      check("ex_pc", bus.ex_pc, m_pc);
      check("ex_a", bus.ex_a, m_a);
      check("ex_b", bus.ex_b, m_b);
      if (m_op != 6'h00 || was_reset) check("ex_imm", bus.ex_imm, m_imm);
      check("ex_op", {26'b0, bus.ex_op}, {26'b0, m_op});
      check("ex_funct", {26'b0, bus.ex_funct}, {26'b0, m_funct});
      check("ex_wa", {27'b0, bus.ex_wa}, {27'b0, m_wa});
      check("ex_reg_we", {31'b0, bus.ex_reg_we}, {31'b0, m_wa != 0});
      check("ex_is_load", {31'b0, bus.ex_is_load}, {31'b0, m_load});
    end
  endtask

  task automatic present(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    bus.if_valid = v;
    bus.if_instr = ins;
    bus.if_pc    = pc;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [5:0]  op;
    ins = $urandom;
    case ($urandom_range(0, 8))
      0: op = 6'h00; 1: op = 6'h08; 2: op = 6'h23; 3: op = 6'h0D;
      4: op = 6'h2B; 5: op = 6'h04; 6: op = 6'h02; 7: op = 6'h3F;
      default: op = 6'($urandom);
    endcase
    ins[31:26] = op;
    if (op != 6'h02) begin
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      ins[15:11] = 5'($urandom_range(0, 7));
    end
    return ins;
  endfunction

  initial begin
    bus.if_valid = 0; bus.if_instr = 0; bus.if_pc = 0;
    bus.rf_rd0 = 32'h1111_0000; bus.rf_rd1 = 32'h2222_0000;
    bus.wb_we = 0; bus.wb_wa = 0; bus.wb_wd = 0;
    bus.flush = 0; bus.ex_ready = 1;

    // Reset held with fetch valid
    rst_n = 0;
    present(1, 32'h2001_0005, 32'h100);
    cycle();
    cycle();
    check("rst ex_valid", {31'b0, bus.ex_valid}, 32'd0);
    check("rst ex_a", bus.ex_a, 32'd0);
    check("rst ex_wa", {27'b0, bus.ex_wa}, 32'd0);

    // addi $1,$0,5
    rst_n = 1;
    cycle();
    check("addi ex_valid", {31'b0, bus.ex_valid}, 32'd1);
    check("addi ex_imm", bus.ex_imm, 32'd5);
    check("addi ex_wa", {27'b0, bus.ex_wa}, 32'd1);
    check("addi ex_reg_we", {31'b0, bus.ex_reg_we}, 32'd1);

    // Bypass of a same-edge write
    bus.rf_rd0 = 32'h11; bus.wb_we = 1; bus.wb_wa = 2; bus.wb_wd = 32'hABCD;
    present(1, 32'h0044_1820, 32'h104);
    cycle();
    check("byp ex_a", bus.ex_a, 32'hABCD);
    check("byp ex_wa", {27'b0, bus.ex_wa}, 32'd3);
    bus.wb_wa = 0;
    present(1, 32'h0004_1820, 32'h108);
    cycle();
    check("r0 ex_a", bus.ex_a, 32'h11);
    bus.wb_we = 0;

    // Load-use stall: lw $5,4($0) then add $6,$5,$7
    present(1, 32'h8C05_0004, 32'h10C);
    cycle();
    present(1, 32'h00A7_3020, 32'h110);
    #1 check("lu id_ready", {31'b0, bus.id_ready}, 32'd0);
    cycle();
    check("lu bubble", {31'b0, bus.ex_valid}, 32'd0);
    cycle();
    check("lu accepted", {31'b0, bus.ex_valid}, 32'd1);
    check("lu ex_wa", {27'b0, bus.ex_wa}, 32'd6);
    // Independent add right after lw: no stall
    present(1, 32'h8C05_0004, 32'h114);
    cycle();
    present(1, 32'h0107_3020, 32'h118);
    cycle();
    check("nolu valid", {31'b0, bus.ex_valid}, 32'd1);
    check("nolu pc", bus.ex_pc, 32'h118);

    // Backpressure holding ori $9,$0,0xFFFF
    present(1, 32'h3409_FFFF, 32'h11C);
    cycle();
    check("ori ex_imm", bus.ex_imm, 32'h0000_FFFF);
    bus.ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp id_ready", {31'b0, bus.id_ready}, 32'd0);
      check("bp ex_pc", bus.ex_pc, 32'h11C);
    end
    bus.ex_ready = 1;
    present(1, 32'h2009_FFFF, 32'h120);
    cycle();
    check("addi sx imm", bus.ex_imm, 32'hFFFF_FFFF);

    // Flush beats a completing handshake
    bus.flush = 1;
    present(1, 32'h2001_0005, 32'h124);
    cycle();
    check("flush ex_valid", {31'b0, bus.ex_valid}, 32'd0);
    bus.flush = 0;

    // No-destination instructions
    present(1, 32'hAC22_0008, 32'h128);
    cycle();
    check("sw ex_reg_we", {31'b0, bus.ex_reg_we}, 32'd0);
    present(1, 32'h1022_0003, 32'h12C);
    cycle();
    check("beq ex_wa", {27'b0, bus.ex_wa}, 32'd0);
    present(1, 32'hFC00_0000, 32'h130);
    cycle();
    check("unk ex_reg_we", {31'b0, bus.ex_reg_we}, 32'd0);
    check("unk ex_imm", bus.ex_imm, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst_n        = ($urandom_range(0, 99) >= 3);
      bus.flush    = ($urandom_range(0, 99) < 8);
      bus.ex_ready = ($urandom_range(0, 99) < 80);
      present($urandom_range(0, 99) < 85, rand_instr(), $urandom);
      bus.rf_rd0 = $urandom;
      bus.rf_rd1 = $urandom;
      bus.wb_we  = 1'($urandom_range(0, 1));
      bus.wb_wa  = 5'($urandom_range(0, 7));
      bus.wb_wd  = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
